id_hazard_ctrl: RTL and testbench
=================================

Name: id_hazard_ctrl

Overview:
- Hazard controller for the 5-stage MIPS pipeline. It drives the ID-stage forwarding muxes, the PC/IF-ID stall, the ID/EX bubble and the IF/ID flush.
- Keeps its own shadow copy of the EX/MEM/WB destination registers, so the datapath only presents the instruction currently in ID.
- Branches resolve in ID. Because of that, the controller also covers branch-operand hazards, load-use hazards and taken-branch flushes.
- Maintains saturating stall and flush counters for performance debug.

Parameters:
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  asynchronous reset, active-high
- id_valid_i  in  1  the instruction in ID is valid (not a bubble)
- id_rs_i  in  5  rs field of the ID instruction
- id_rt_i  in  5  rt field of the ID instruction
- id_use_rs_i  in  1  the ID instruction reads rs
- id_use_rt_i  in  1  the ID instruction reads rt
- id_is_branch_i  in  1  the ID instruction is beq/bne; it compares its operands in ID
- id_dst_i  in  5  destination register of the ID instruction
- id_reg_write_i  in  1  the ID instruction writes the register file
- id_mem_read_i  in  1  the ID instruction is a load
- branch_taken_i  in  1  branch comparison result in ID; meaningful only when id_is_branch_i=1
- stall_o  out  1  hold the PC and IF/ID this cycle
- bubble_o  out  1  zero the control bits written into ID/EX
- flush_ifid_o  out  1  replace the IF/ID contents with a NOP at the next edge
- fwd_rs_sel_o  out  2  ID rs mux select: 00 regfile, 01 MEM-stage ALU result, 10 WB data
- fwd_rt_sel_o  out  2  ID rt mux select, same encoding as fwd_rs_sel_o
- stall_cnt_o  out  CNT_W  number of stalled cycles, saturating
- flush_cnt_o  out  CNT_W  number of taken-branch flushes, saturating

Behaviour:
- Shadow pipeline registers, each with fields {dst, wr, ld}: ex, mem, wb. On reset all fields are 0.
- Each rising edge: wb<=mem, mem<=ex.
- ex loads the ID fields when issue=id_valid_i&&!stall_o; otherwise ex loads a bubble (wr=0, ld=0).
- wr is forced to 0 whenever dst==0. $zero never produces a hazard or a forward.
- A source s (rs or rt) is live when its id_use bit=1 and id_valid_i=1.
- Match conditions for a live source s:
  - hitEX = ex.wr && ex.dst==s
  - hitMEM = mem.wr && mem.dst==s
  - hitWB = wb.wr && wb.dst==s
- stall_o=1 if any live source satisfies any of these:
  - hitEX && (ex.ld || id_is_branch_i): load-use hazard, or a branch needing a value still in EX.
  - hitMEM && mem.ld && id_is_branch_i: a branch needing load data that is not yet available.
- bubble_o = stall_o. stall_o and bubble_o are combinational from the shadow state and the ID inputs.
- fwd_*_sel_o, evaluated per source with the source not live giving 00:
  - hitMEM && !mem.ld gives 01.
  - otherwise hitWB gives 10.
  - otherwise 00.
  - MEM has priority over WB when both match.
  - The selects are computed even while stalled; the datapath ignores them then.
- flush_ifid_o = issue && id_is_branch_i && branch_taken_i. It is combinational and is never asserted in a stalled cycle.
- Cause FSM, one register, state reset value RUN:
  - RUN: stall asserted with the load-use condition → LU; stall asserted with only branch conditions → BR.
  - LU and BR: return to RUN when stall_o=0; if the stall persists, re-evaluate the cause every cycle.
  - The FSM is for debug only and does not affect any output.
- stall_cnt_o increments on every edge where stall_o=1. flush_cnt_o increments on every edge where flush_ifid_o=1. Both saturate at 2^CNT_W-1 and reset to 0.
- Reset mid-stall: the shadow registers clear immediately, and stall_o drops in the same cycle that rst_i is high.
- All outputs are 0 during reset and immediately after reset, provided id_valid_i=0.
- Maximum stall length:
  - Branch on a load result: 2 cycles.
  - Branch on an ALU result: 1 cycle.
  - Load-use for a non-branch consumer: 1 cycle.

Decomposition:
- Shared package holds:
  - FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10
  - cause state encodings RUN/LU/BR
  - the {dst,wr,ld} shadow-entry struct
- One natural sub-module, hazard_match, used twice (rs and rt). It is combinational: it takes the shadow entries plus one source and outputs stall_req and sel.

Test Plan:
- lw $2 issued, next instruction add $3,$2,$4 → stall_o=1 and bubble_o=1 for exactly 1 cycle; then fwd_rs_sel_o=10 when the load reaches WB; stall_cnt_o=1.
- add $5,$1,$1 then beq $5,$0 → 1 stall cycle; next cycle fwd_rs_sel_o=01.
- lw $6 then beq $6,$7 → 2 stall cycles; then fwd_rs_sel_o=10; stall_cnt_o=2.
- Non-stalling branch with branch_taken_i=1 → flush_ifid_o=1 for 1 cycle; flush_cnt_o=1. Same branch held in a stall cycle with branch_taken_i=1 → flush_ifid_o=0.
- Writes to $0 in EX/MEM/WB followed by a reader of $0 → no stall, sel=00. Same dst in MEM (ALU) and WB → sel=01 (MEM priority).
- Assert rst_i during the second cycle of a lw→beq stall → stall_o=0 immediately; counters return to 0. With CNT_W=2 and 5 stall cycles → stall_cnt_o=3 (saturated).

Source files
------------

// File: rtl/id_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_hazard_ctrl_pkg
// Description : Shared types and encodings for the ID-stage hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package id_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        RUN = 2'd0,
        LU  = 2'd1,
        BR  = 2'd2
    } cause_e;

    typedef struct packed {
        logic [4:0] dst;
        logic       wr;
        logic       ld;
    } shadow_t;

    localparam shadow_t c_SHADOW_BUBBLE = '{dst: 5'd0, wr: 1'b0, ld: 1'b0};

    // Writes to $zero are dropped here so no downstream match can ever fire on r0.
    function automatic shadow_t make_entry(input logic [4:0] dst,
                                           input logic       wr,
                                           input logic       ld);
        shadow_t e;
        e.dst = dst;
        e.wr  = wr && (dst != 5'd0);
        e.ld  = ld;
        return e;
    endfunction

endpackage : id_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/id_hazard_ctrl_hazard_match.sv
`default_nettype none
// ============================================================================
// Module      : hazard_match
// Description : Per-source comparison of one ID operand against the shadow
//               EX/MEM/WB entries; yields stall requests and a forward select.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_match
    import id_hazard_ctrl_pkg::*;
(
    input  logic       i_live,
    input  logic [4:0] i_src,
    input  logic       i_is_branch,
    input  shadow_t    i_ex,
    input  shadow_t    i_mem,
    input  shadow_t    i_wb,
    output logic       o_stall_lu,
    output logic       o_stall_br,
    output logic [1:0] o_sel
);

    logic w_hit_ex;
    logic w_hit_mem;
    logic w_hit_wb;
    logic w_unused_wb_ld;

    assign w_unused_wb_ld = i_wb.ld;

    always_comb begin
        w_hit_ex   = i_live && i_ex.wr  && (i_ex.dst  == i_src);
        w_hit_mem  = i_live && i_mem.wr && (i_mem.dst == i_src);
        w_hit_wb   = i_live && i_wb.wr  && (i_wb.dst  == i_src);

        o_stall_lu = w_hit_ex && i_ex.ld;
        // Branches compare in ID, so they also wait on ALU results in EX
        // and on load data still in MEM.
        o_stall_br = i_is_branch && (w_hit_ex || (w_hit_mem && i_mem.ld));

        o_sel = FWD_REG;
        if (w_hit_mem && !i_mem.ld) begin
            o_sel = FWD_MEM;
        end else if (w_hit_wb) begin
            o_sel = FWD_WB;
        end
    end

endmodule : hazard_match
`default_nettype wire

// File: rtl/id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : id_hazard_ctrl
// Description : ID-stage hazard controller: stall/bubble, IF/ID flush, ID
//               forwarding selects, debug cause FSM and perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_use_rs_i,
    input  logic             id_use_rt_i,
    input  logic             id_is_branch_i,
    input  logic [4:0]       id_dst_i,
    input  logic             id_reg_write_i,
    input  logic             id_mem_read_i,
    input  logic             branch_taken_i,
    output logic             stall_o,
    output logic             bubble_o,
    output logic             flush_ifid_o,
    output logic [1:0]       fwd_rs_sel_o,
    output logic [1:0]       fwd_rt_sel_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    shadow_t          r_ex;
    shadow_t          r_mem;
    shadow_t          r_wb;
    cause_e           r_cause;
    cause_e           w_cause_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_lu_rs, w_br_rs, w_lu_rt, w_br_rt;
    logic w_stall_lu;
    logic w_stall;
    logic w_issue;
    logic w_flush;

    hazard_match u_match_rs (
        .i_live      (id_valid_i && id_use_rs_i),
        .i_src       (id_rs_i),
        .i_is_branch (id_is_branch_i),
        .i_ex        (r_ex),
        .i_mem       (r_mem),
        .i_wb        (r_wb),
        .o_stall_lu  (w_lu_rs),
        .o_stall_br  (w_br_rs),
        .o_sel       (fwd_rs_sel_o)
    );

    hazard_match u_match_rt (
        .i_live      (id_valid_i && id_use_rt_i),
        .i_src       (id_rt_i),
        .i_is_branch (id_is_branch_i),
        .i_ex        (r_ex),
        .i_mem       (r_mem),
        .i_wb        (r_wb),
        .o_stall_lu  (w_lu_rt),
        .o_stall_br  (w_br_rt),
        .o_sel       (fwd_rt_sel_o)
    );

    assign w_stall_lu   = w_lu_rs || w_lu_rt;
    assign w_stall      = w_stall_lu || w_br_rs || w_br_rt;
    assign w_issue      = id_valid_i && !w_stall;
    assign w_flush      = w_issue && id_is_branch_i && branch_taken_i;

    assign stall_o      = w_stall;
    assign bubble_o     = w_stall;
    assign flush_ifid_o = w_flush;
    assign stall_cnt_o  = r_stall_cnt;
    assign flush_cnt_o  = r_flush_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ex  <= c_SHADOW_BUBBLE;
            r_mem <= c_SHADOW_BUBBLE;
            r_wb  <= c_SHADOW_BUBBLE;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_issue ? make_entry(id_dst_i, id_reg_write_i, id_mem_read_i)
                             : c_SHADOW_BUBBLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    // Debug-only stall cause tracker; load-use takes precedence over branch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cause <= RUN;
        end else begin
            r_cause <= w_cause_nxt;
        end
    end

    always_comb begin
        w_cause_nxt = r_cause;
        case (r_cause)
            RUN, LU, BR: begin
                if (!w_stall) begin
                    w_cause_nxt = RUN;
                end else if (w_stall_lu) begin
                    w_cause_nxt = LU;
                end else begin
                    w_cause_nxt = BR;
                end
            end
            default: w_cause_nxt = RUN;
        endcase
    end

endmodule : id_hazard_ctrl
`default_nettype wire

// File: tb/tb_id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_hazard_ctrl
// Description : Directed self-checking bench for id_hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       valid, use_rs, use_rt, is_br, rw, mr, taken;
    logic [4:0] rs, rt, dst;

    logic        stall, bubble, flush;
    logic [1:0]  rs_sel, rt_sel;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_stall, s_bubble, s_flush;
    logic [1:0]  s_rs_sel, s_rt_sel;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int total = 0;
    int bad   = 0;

    id_hazard_ctrl dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(valid), .id_rs_i(rs), .id_rt_i(rt),
        .id_use_rs_i(use_rs), .id_use_rt_i(use_rt), .id_is_branch_i(is_br),
        .id_dst_i(dst), .id_reg_write_i(rw), .id_mem_read_i(mr),
        .branch_taken_i(taken), .stall_o(stall), .bubble_o(bubble),
        .flush_ifid_o(flush), .fwd_rs_sel_o(rs_sel), .fwd_rt_sel_o(rt_sel),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    id_hazard_ctrl #(.CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .id_valid_i(valid), .id_rs_i(rs), .id_rt_i(rt),
        .id_use_rs_i(use_rs), .id_use_rt_i(use_rt), .id_is_branch_i(is_br),
        .id_dst_i(dst), .id_reg_write_i(rw), .id_mem_read_i(mr),
        .branch_taken_i(taken), .stall_o(s_stall), .bubble_o(s_bubble),
        .flush_ifid_o(s_flush), .fwd_rs_sel_o(s_rs_sel), .fwd_rt_sel_o(s_rt_sel),
        .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] a, input logic [4:0] b,
                          input logic ua, input logic ub, input logic br,
                          input logic [4:0] d, input logic w, input logic m,
                          input logic t);
        valid = v; rs = a; rt = b; use_rs = ua; use_rt = ub; is_br = br;
        dst = d; rw = w; mr = m; taken = t;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nop();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        nop();
        #1;
        chk("rst_stall",     {31'd0, stall},  32'd0);
        chk("rst_bubble",    {31'd0, bubble}, 32'd0);
        chk("rst_flush",     {31'd0, flush},  32'd0);
        chk("rst_rs_sel",    {30'd0, rs_sel}, 32'd0);
        chk("rst_rt_sel",    {30'd0, rt_sel}, 32'd0);
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        chk("rst_sat_cnt",   {30'd0, s_stall_cnt}, 32'd0);
        tick();
        rst = 1'b0;
        #1;

        // lw $2 ; add $3,$2,$4 ; sub $8,$2,$0
        set_id(1, 1, 0, 1, 0, 0, 2, 1, 1, 0); #1;
        chk("lu_lw_nostall", {31'd0, stall}, 32'd0);
        tick();
        set_id(1, 2, 4, 1, 1, 0, 3, 1, 0, 0); #1;
        chk("lu_stall",  {31'd0, stall},  32'd1);
        chk("lu_bubble", {31'd0, bubble}, 32'd1);
        tick();
        chk("lu_released", {31'd0, stall}, 32'd0);
        chk("lu_cnt",      {16'd0, stall_cnt}, 32'd1);
        tick();
        set_id(1, 2, 0, 1, 1, 0, 8, 1, 0, 0); #1;
        chk("lu_wb_fwd", {30'd0, rs_sel}, 32'd2);
        chk("lu_rt_r0",  {30'd0, rt_sel}, 32'd0);
        chk("lu_cnt2",   {16'd0, stall_cnt}, 32'd1);

        // add $5,$1,$1 ; beq $5,$0
        do_reset();
        set_id(1, 1, 1, 1, 1, 0, 5, 1, 0, 0); #1;
        tick();
        set_id(1, 5, 0, 1, 1, 1, 0, 0, 0, 0); #1;
        chk("alu_br_stall", {31'd0, stall}, 32'd1);
        chk("alu_br_noflush", {31'd0, flush}, 32'd0);
        tick();
        chk("alu_br_release", {31'd0, stall},  32'd0);
        chk("alu_br_memfwd",  {30'd0, rs_sel}, 32'd1);
        chk("alu_br_rt",      {30'd0, rt_sel}, 32'd0);
        chk("alu_br_cnt",     {16'd0, stall_cnt}, 32'd1);

        // lw $6 ; beq $6,$7
        do_reset();
        set_id(1, 1, 0, 1, 0, 0, 6, 1, 1, 0); #1;
        tick();
        set_id(1, 6, 7, 1, 1, 1, 0, 0, 0, 0); #1;
        chk("ld_br_stall1", {31'd0, stall}, 32'd1);
        tick();
        chk("ld_br_stall2",  {31'd0, stall},  32'd1);
        chk("ld_br_bubble2", {31'd0, bubble}, 32'd1);
        tick();
        chk("ld_br_release", {31'd0, stall},  32'd0);
        chk("ld_br_wbfwd",   {30'd0, rs_sel}, 32'd2);
        chk("ld_br_rt",      {30'd0, rt_sel}, 32'd0);
        chk("ld_br_cnt",     {16'd0, stall_cnt}, 32'd2);

        // Taken branch flush, then taken branch held in a stall
        do_reset();
        set_id(1, 9, 10, 1, 1, 1, 0, 0, 0, 1); #1;
        chk("fl_flush",   {31'd0, flush}, 32'd1);
        chk("fl_nostall", {31'd0, stall}, 32'd0);
        tick();
        nop(); #1;
        chk("fl_drop", {31'd0, flush}, 32'd0);
        chk("fl_cnt",  {16'd0, flush_cnt}, 32'd1);
        set_id(1, 1, 1, 1, 1, 0, 9, 1, 0, 0); #1;
        tick();
        set_id(1, 9, 10, 1, 1, 1, 0, 0, 0, 1); #1;
        chk("fl_stall",        {31'd0, stall}, 32'd1);
        chk("fl_stall_noflsh", {31'd0, flush}, 32'd0);
        tick();
        chk("fl_cnt_held", {16'd0, flush_cnt}, 32'd1);
        chk("fl_after",    {31'd0, flush},     32'd1);

        // Writes to $0 in EX/MEM/WB, then a reader of $0
        do_reset();
        set_id(1, 1, 1, 1, 1, 0, 0, 1, 0, 0); tick();
        set_id(1, 1, 0, 1, 0, 0, 0, 1, 1, 0); tick();
        set_id(1, 1, 1, 1, 1, 0, 0, 1, 0, 0); tick();
        set_id(1, 0, 0, 1, 1, 1, 0, 0, 0, 0); #1;
        chk("r0_nostall", {31'd0, stall},  32'd0);
        chk("r0_rs_sel",  {30'd0, rs_sel}, 32'd0);
        chk("r0_rt_sel",  {30'd0, rt_sel}, 32'd0);

        // Same dst in MEM and WB: MEM wins
        do_reset();
        set_id(1, 1, 1, 1, 1, 0, 11, 1, 0, 0); tick();
        set_id(1, 2, 2, 1, 1, 0, 11, 1, 0, 0); tick();
        nop(); tick();
        set_id(1, 11, 11, 1, 1, 0, 12, 1, 0, 0); #1;
        chk("prio_nostall", {31'd0, stall},  32'd0);
        chk("prio_rs",      {30'd0, rs_sel}, 32'd1);
        chk("prio_rt",      {30'd0, rt_sel}, 32'd1);

        // Reset during second cycle of a lw -> beq stall
        do_reset();
        set_id(1, 1, 0, 1, 0, 0, 6, 1, 1, 0); tick();
        set_id(1, 6, 7, 1, 1, 1, 0, 0, 0, 0); tick();
        chk("mid_stall2", {31'd0, stall}, 32'd1);
        rst = 1'b1; #1;
        chk("mid_rst_stall",  {31'd0, stall},  32'd0);
        chk("mid_rst_bubble", {31'd0, bubble}, 32'd0);
        chk("mid_rst_cnt",    {16'd0, stall_cnt}, 32'd0);
        chk("mid_rst_sat",    {30'd0, s_stall_cnt}, 32'd0);
        chk("mid_rst_rs_sel", {30'd0, rs_sel}, 32'd0);
        tick();
        rst = 1'b0;
        nop(); #1;

        // Five stall cycles: 16-bit counter reads 5, 2-bit counter saturates at 3
        set_id(1, 1, 0, 1, 0, 0, 6, 1, 1, 0); tick();
        set_id(1, 6, 7, 1, 1, 1, 0, 0, 0, 0); tick(); tick(); tick();
        set_id(1, 1, 0, 1, 0, 0, 6, 1, 1, 0); tick();
        set_id(1, 6, 7, 1, 1, 1, 0, 0, 0, 0); tick(); tick(); tick();
        set_id(1, 1, 1, 1, 1, 0, 5, 1, 0, 0); tick();
        set_id(1, 5, 0, 1, 1, 1, 0, 0, 0, 0); tick(); tick();
        nop(); #1;
        chk("sat_cnt16", {16'd0, stall_cnt},   32'd5);
        chk("sat_cnt2",  {30'd0, s_stall_cnt}, 32'd3);
        chk("sat_idle",  {31'd0, s_stall},     32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_id_hazard_ctrl
`default_nettype wire
